multicycle_control: RTL and testbench

- Main control unit for the 8-bit multicycle MIPS datapath.
- Drives the ALU through `ALUControl` and consumes its `Zero` flag.
- Sequences every instruction through a Moore state machine and generates all datapath enables and mux selects.
- Contains the ALU decoder, which maps ALUOp and funct to the 3-bit `ALUControl` code.

---
 rtl/multicycle_control.sv | 176 +++++++++++++++++
 tb/tb_multicycle_control.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// multicycle_control: Moore FSM controller and ALU decoder for the 8-bit multicycle MIPS datapath.
// Define MC_BNE_EN to add the bne instruction (state 10, PCEn = ~Zero).
module multicycle_control (
    input  logic       clock,
    input  logic       reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    output logic [2:0] ALUControl,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       PCEn,
    output logic [3:0] State
);
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] JUMP    = 4'd11;
`ifdef MC_BNE_EN
    localparam logic [3:0] BNE     = 4'd10;
    localparam logic [5:0] OP_BNE  = 6'b000101;
`endif
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0] state_q, state_d, cur;
    logic [1:0] alu_op;
    logic [2:0] funct_ctl;
    logic       pc_write, branch;
`ifdef MC_BNE_EN
    logic       bne_br;
`endif

    always_ff @(posedge clock) begin
        if (reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    assign State = state_q;

    always_comb begin
        state_d = FETCH;
        case (state_q)
            FETCH:   state_d = DECODE;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_R:         state_d = EXECUTE;
                    OP_BEQ:       state_d = BRANCH;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
`ifdef MC_BNE_EN
                    OP_BNE:       state_d = BNE;
`endif
                    default:      state_d = FETCH;
                endcase
            end
            MEMADR:  state_d = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   state_d = MEMWB;
            EXECUTE: state_d = ALUWB;
            ADDIEX:  state_d = ALUWB;
            default: state_d = FETCH;
        endcase
    end

    // Reset decodes as FETCH so the muxes are steady, with every write strobe masked.
    assign cur = reset ? FETCH : state_q;

    always_comb begin
        ALUSrcA  = 1'b0;
        ALUSrcB  = 2'b00;
        PCSrc    = 2'b00;
        IorD     = 1'b0;
        MemWrite = 1'b0;
        IRWrite  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        RegWrite = 1'b0;
        alu_op   = 2'b00;
        pc_write = 1'b0;
        branch   = 1'b0;
`ifdef MC_BNE_EN
        bne_br   = 1'b0;
`endif
        case (cur)
            FETCH: begin
                IRWrite  = 1'b1;
                ALUSrcB  = 2'b01;
                pc_write = 1'b1;
            end
            DECODE:  ALUSrcB = 2'b11;
            MEMADR, ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD:   IorD = 1'b1;
            MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b10;
            end
            ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = (Op == OP_R);
            end
            BRANCH: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                branch  = 1'b1;
            end
`ifdef MC_BNE_EN
            BNE: begin
                ALUSrcA = 1'b1;
                alu_op  = 2'b01;
                PCSrc   = 2'b01;
                bne_br  = 1'b1;
            end
`endif
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
            end
            default: ;
        endcase
        if (reset) begin
            IRWrite  = 1'b0;
            pc_write = 1'b0;
        end
    end

    always_comb begin
        funct_ctl = 3'b010;
        case (Funct)
            6'b100010: funct_ctl = 3'b110;
            6'b100100: funct_ctl = 3'b000;
            6'b100101: funct_ctl = 3'b001;
            6'b101010: funct_ctl = 3'b111;
            default:   funct_ctl = 3'b010;
        endcase
    end

    assign ALUControl = (alu_op == 2'b01) ? 3'b110 :
                        (alu_op == 2'b10) ? funct_ctl : 3'b010;

`ifdef MC_BNE_EN
    assign PCEn = pc_write | (branch & Zero) | (bne_br & ~Zero);
`else
    assign PCEn = pc_write | (branch & Zero);
`endif
endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: table-driven cycle-by-cycle check of the multicycle controller,
// plus hand-written reset-hold and cycles-per-instruction sequences.
module tb_multicycle_control;
    logic       clock = 1'b0;
    logic       reset;
    logic [5:0] Op, Funct;
    logic       Zero;
    logic [2:0] ALUControl;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB, PCSrc;
    logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn;
    logic [3:0] State;

    multicycle_control dut (
        .clock(clock), .reset(reset), .Op(Op), .Funct(Funct), .Zero(Zero),
        .ALUControl(ALUControl), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSrc(PCSrc),
        .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCEn(PCEn), .State(State)
    );

    always #5 clock = ~clock;

    // {ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, PCEn}
    localparam logic [14:0] C_FETCH  = {3'b010, 1'b0, 2'b01, 2'b00, 7'b0010001};
    localparam logic [14:0] C_RST    = {3'b010, 1'b0, 2'b01, 2'b00, 7'b0000000};
    localparam logic [14:0] C_DECODE = {3'b010, 1'b0, 2'b11, 2'b00, 7'b0000000};
    localparam logic [14:0] C_MEMADR = {3'b010, 1'b1, 2'b10, 2'b00, 7'b0000000};
    localparam logic [14:0] C_MEMRD  = {3'b010, 1'b0, 2'b00, 2'b00, 7'b1000000};
    localparam logic [14:0] C_MEMWB  = {3'b010, 1'b0, 2'b00, 2'b00, 7'b0000110};
    localparam logic [14:0] C_MEMWR  = {3'b010, 1'b0, 2'b00, 2'b00, 7'b1100000};
    localparam logic [14:0] C_ALUWBR = {3'b010, 1'b0, 2'b00, 2'b00, 7'b0001010};
    localparam logic [14:0] C_ALUWBI = {3'b010, 1'b0, 2'b00, 2'b00, 7'b0000010};
    localparam logic [14:0] C_BR0    = {3'b110, 1'b1, 2'b00, 2'b01, 7'b0000000};
    localparam logic [14:0] C_BR1    = {3'b110, 1'b1, 2'b00, 2'b01, 7'b0000001};
    localparam logic [14:0] C_JUMP   = {3'b010, 1'b0, 2'b00, 2'b10, 7'b0000001};

    function automatic logic [14:0] c_exec(input logic [2:0] aluc);
        return {aluc, 1'b1, 2'b00, 2'b00, 7'b0000000};
    endfunction

    typedef struct {
        logic        rst;
        logic [5:0]  op;
        logic [5:0]  funct;
        logic        zero;
        logic [3:0]  st;
        logic [14:0] ctl;
    } vec_t;

    vec_t vecs[$];
    int   n_pass = 0;
    int   n_total = 0;

    task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] funct,
                       input logic zero, input logic [3:0] st, input logic [14:0] ctl);
        vec_t v;
        v.rst = rst; v.op = op; v.funct = funct; v.zero = zero; v.st = st; v.ctl = ctl;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic rtype(input logic [5:0] f, input logic [2:0] aluc);
        add(0, 6'b000000, f, 0, 4'd0, C_FETCH);
        add(0, 6'b000000, f, 0, 4'd1, C_DECODE);
        add(0, 6'b000000, f, 0, 4'd6, c_exec(aluc));
        add(0, 6'b000000, f, 0, 4'd7, C_ALUWBR);
    endtask

    // Runs one instruction from FETCH and counts edges until State returns to FETCH.
    task automatic cpi(input string name, input logic [5:0] op, input int exp);
        int n;
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        Op = op;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (State !== 4'd0 && n < 20);
        check(name, n, exp);
    endtask

    initial begin
        reset = 1'b1; Op = 6'b0; Funct = 6'b0; Zero = 1'b0;
        add(1, 6'b100011, 0, 0, 4'd0, C_RST);
        // lw
        add(0, 6'b100011, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b100011, 0, 0, 4'd1, C_DECODE);
        add(0, 6'b100011, 0, 0, 4'd2, C_MEMADR);
        add(0, 6'b100011, 0, 0, 4'd3, C_MEMRD);
        add(0, 6'b100011, 0, 0, 4'd4, C_MEMWB);
        rtype(6'b100000, 3'b010);
        rtype(6'b100010, 3'b110);
        rtype(6'b100100, 3'b000);
        rtype(6'b100101, 3'b001);
        rtype(6'b101010, 3'b111);
        rtype(6'b111111, 3'b010);
        // beq taken, then not taken
        add(0, 6'b000100, 0, 1, 4'd0, C_FETCH);
        add(0, 6'b000100, 0, 1, 4'd1, C_DECODE);
        add(0, 6'b000100, 0, 1, 4'd8, C_BR1);
        add(0, 6'b000100, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b000100, 0, 0, 4'd1, C_DECODE);
        add(0, 6'b000100, 0, 0, 4'd8, C_BR0);
        // sw then j
        add(0, 6'b101011, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b101011, 0, 0, 4'd1, C_DECODE);
        add(0, 6'b101011, 0, 0, 4'd2, C_MEMADR);
        add(0, 6'b101011, 0, 0, 4'd5, C_MEMWR);
        add(0, 6'b000010, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b000010, 0, 0, 4'd1, C_DECODE);
        add(0, 6'b000010, 0, 0, 4'd11, C_JUMP);
        // addi writes rt
        add(0, 6'b001000, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b001000, 0, 0, 4'd1, C_DECODE);
        add(0, 6'b001000, 0, 0, 4'd9, C_MEMADR);
        add(0, 6'b001000, 0, 0, 4'd7, C_ALUWBI);
        // unknown opcode is a two-cycle nop
        add(0, 6'b111111, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b111111, 0, 0, 4'd1, C_DECODE);
        // bne opcode
        add(0, 6'b000101, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b000101, 0, 0, 4'd1, C_DECODE);
`ifdef MC_BNE_EN
        add(0, 6'b000101, 0, 0, 4'd10, C_BR1);
`endif
        // reset during MEMRD, then during MEMWR
        add(0, 6'b100011, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b100011, 0, 0, 4'd1, C_DECODE);
        add(0, 6'b100011, 0, 0, 4'd2, C_MEMADR);
        add(1, 6'b100011, 0, 1, 4'd3, C_RST);
        add(0, 6'b101011, 0, 0, 4'd0, C_FETCH);
        add(0, 6'b101011, 0, 0, 4'd1, C_DECODE);
        add(0, 6'b101011, 0, 0, 4'd2, C_MEMADR);
        add(1, 6'b101011, 0, 0, 4'd5, C_RST);
        add(0, 6'b101011, 0, 0, 4'd0, C_FETCH);

        @(posedge clock);
        @(posedge clock);
        foreach (vecs[i]) begin
            @(negedge clock);
            reset = vecs[i].rst;
            Op    = vecs[i].op;
            Funct = vecs[i].funct;
            Zero  = vecs[i].zero;
            #1;
            check($sformatf("vec%0d state", i), {28'd0, State}, {28'd0, vecs[i].st});
            check($sformatf("vec%0d ctl", i),
                  {17'd0, ALUControl, ALUSrcA, ALUSrcB, PCSrc, IorD, MemWrite, IRWrite,
                   RegDst, MemtoReg, RegWrite, PCEn},
                  {17'd0, vecs[i].ctl});
        end

        // Held reset with a beq in flight and Zero high: no strobe may fire.
        @(negedge clock);
        reset = 1'b1; Op = 6'b000100; Zero = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            check($sformatf("rst_hold%0d strobes", k),
                  {28'd0, PCEn, IRWrite, MemWrite, RegWrite}, 32'd0);
        end

        cpi("cpi lw", 6'b100011, 5);
        cpi("cpi sw", 6'b101011, 4);
        cpi("cpi rtype", 6'b000000, 4);
        cpi("cpi addi", 6'b001000, 4);
        cpi("cpi beq", 6'b000100, 3);
        cpi("cpi j", 6'b000010, 3);
        cpi("cpi unknown", 6'b111111, 2);
`ifdef MC_BNE_EN
        cpi("cpi bne", 6'b000101, 3);
`else
        cpi("cpi bne", 6'b000101, 2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
